// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared types and default sizes for the fila_ctrl sequencer:
//               FSM state encoding, arbiter grant identifiers and the default
//               word width / queue depth / occupancy width / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_DEPTH   = 8;
    localparam int c_DEF_LEN_W   = 4;
    localparam int c_DEF_TIMEOUT = 15;
    localparam int c_DROP_CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENQ      = 3'd1,
        S_WAIT_ENQ = 3'd2,
        S_ACK      = 3'd3,
        S_DEQ      = 3'd4,
        S_WAIT_DEQ = 3'd5
    } fila_ctrl_state_t;

    typedef enum logic {
        G_ENQ = 1'b0,
        G_DEQ = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter with one-hot grant. On a tie
//               the requester that did not win last time is granted. The
//               last-grant memory only moves when the grant is accepted.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset (last-grant = DEQ)
//               i_req_enq  - enqueue side request
//               i_req_deq  - dequeue side request
//               i_accept   - the current grant is being consumed this cycle
//               o_gnt_enq  - enqueue granted (one-hot with o_gnt_deq)
//               o_gnt_deq  - dequeue granted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fila_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_enq,
    input  logic i_req_deq,
    input  logic i_accept,
    output logic o_gnt_enq,
    output logic o_gnt_deq
);

    grant_t r_last;

    always_comb begin
        o_gnt_enq = 1'b0;
        o_gnt_deq = 1'b0;
        if (i_req_enq && i_req_deq) begin
            if (r_last == G_DEQ) begin
                o_gnt_enq = 1'b1;
            end else begin
                o_gnt_deq = 1'b1;
            end
        end else if (i_req_enq) begin
            o_gnt_enq = 1'b1;
        end else if (i_req_deq) begin
            o_gnt_deq = 1'b1;
        end
    end

    // Reset to DEQ so that the first tie goes to the enqueue side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= G_DEQ;
        end else if (i_accept && o_gnt_enq) begin
            r_last <= G_ENQ;
        end else if (i_accept && o_gnt_deq) begin
            r_last <= G_DEQ;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fila_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fila_ctrl
// Description : Sequences the deserializer -> fila datapath. Accepts completed
//               words from the deserializer, pulses fila enqueue, returns ack,
//               serves user dequeue requests, arbitrates the two round-robin
//               and applies a stall-or-drop policy when fila is full.
// Ports       : clk_100KHz       - sole clock, rising edge
//               reset            - asynchronous active-low reset
//               des_data_in      - deserializer word (valid with des_ready_in)
//               des_ready_in     - deserializer word pending
//               des_ack_out      - word consumed; held until des_ready_in falls
//               fila_len_in      - current fila occupancy
//               fila_enqueue_out - one-cycle enqueue pulse
//               fila_data_out    - word being enqueued
//               fila_dequeue_out - one-cycle dequeue pulse
//               user_dequeue_in  - user dequeue request level (rise = request)
//               busy_out         - FSM not idle
//               drop_count_out   - dropped words + enqueue timeouts, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int DEPTH        = c_DEF_DEPTH,
    parameter int LEN_W        = c_DEF_LEN_W,
    parameter int TIMEOUT      = c_DEF_TIMEOUT,
    parameter int DROP_ON_FULL = 0
)(
    input  logic                    clk_100KHz,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       des_data_in,
    input  logic                    des_ready_in,
    output logic                    des_ack_out,
    input  logic [LEN_W-1:0]        fila_len_in,
    output logic                    fila_enqueue_out,
    output logic [DATA_W-1:0]       fila_data_out,
    output logic                    fila_dequeue_out,
    input  logic                    user_dequeue_in,
    output logic                    busy_out,
    output logic [c_DROP_CNT_W-1:0] drop_count_out
);

    localparam bit                 c_DROP     = (DROP_ON_FULL != 0);
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0]   c_DEPTH    = LEN_W'(DEPTH);

    fila_ctrl_state_t          r_state;
    fila_ctrl_state_t          w_next;
    logic                      r_busy;
    logic [DATA_W-1:0]         r_data;
    logic [LEN_W-1:0]          r_len_snap;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_DROP_CNT_W-1:0]   r_drop;
    logic                      r_deq_prev;
    logic                      r_deq_pend;

    logic w_full;
    logic w_empty;
    logic w_len_moved;
    logic w_timeout;
    logic w_deq_rise;
    logic w_req_enq;
    logic w_idle;
    logic w_gnt_enq;
    logic w_gnt_deq;
    logic w_drop_inc;

    // Occupancy above DEPTH is treated as full.
    assign w_full      = (fila_len_in >= c_DEPTH);
    assign w_empty     = (fila_len_in == '0);
    assign w_len_moved = (fila_len_in != r_len_snap);
    assign w_timeout   = (r_cnt == c_CNT_LAST);
    assign w_deq_rise  = user_dequeue_in && !r_deq_prev;
    assign w_idle      = (r_state == S_IDLE);

    // In stall mode a full queue hides the enqueue request from the arbiter,
    // so a pending dequeue still wins and can free space.
    assign w_req_enq = des_ready_in && (!w_full || c_DROP);

    rr_arb2 u_arb (
        .clk       (clk_100KHz),
        .rst_n     (reset),
        .i_req_enq (w_req_enq),
        .i_req_deq (r_deq_pend),
        .i_accept  (w_idle),
        .o_gnt_enq (w_gnt_enq),
        .o_gnt_deq (w_gnt_deq)
    );

    always_comb begin
        w_next     = r_state;
        w_drop_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_enq) begin
                    // A granted enqueue on a full queue only happens in drop mode.
                    w_next     = w_full ? S_ACK : S_ENQ;
                    w_drop_inc = w_full;
                end else if (w_gnt_deq) begin
                    w_next = w_empty ? S_IDLE : S_DEQ;
                end
            end
            S_ENQ:      w_next = S_WAIT_ENQ;
            S_WAIT_ENQ: begin
                if (w_len_moved) begin
                    w_next = S_ACK;
                end else if (w_timeout) begin
                    w_next     = S_ACK;
                    w_drop_inc = 1'b1;
                end
            end
            S_ACK: begin
                if (!des_ready_in) begin
                    w_next = S_IDLE;
                end
            end
            S_DEQ:      w_next = S_WAIT_DEQ;
            S_WAIT_DEQ: begin
                if (w_len_moved || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_data     <= '0;
            r_len_snap <= '0;
            r_cnt      <= '0;
            r_drop     <= '0;
            r_deq_prev <= 1'b0;
            r_deq_pend <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);
            r_deq_prev <= user_dequeue_in;

            if (w_idle && w_gnt_enq && !w_full) begin
                r_data <= des_data_in;
            end

            // Occupancy seen during the pulse cycle is the reference the wait
            // state compares against.
            if (r_state == S_ENQ || r_state == S_DEQ) begin
                r_len_snap <= fila_len_in;
            end

            if (r_state == S_WAIT_ENQ || r_state == S_WAIT_DEQ) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (w_drop_inc && (r_drop != '1)) begin
                r_drop <= r_drop + c_DROP_CNT_W'(1);
            end

            // Consuming the request wins over a simultaneous edge: that edge
            // arrived while the request was still pending and is merged.
            if (w_idle && w_gnt_deq) begin
                r_deq_pend <= 1'b0;
            end else if (w_deq_rise) begin
                r_deq_pend <= 1'b1;
            end
        end
    end

    assign fila_enqueue_out = (r_state == S_ENQ);
    assign fila_dequeue_out = (r_state == S_DEQ);
    assign des_ack_out      = (r_state == S_ACK);
    assign fila_data_out    = r_data;
    assign busy_out         = r_busy;
    assign drop_count_out   = r_drop;

endmodule
`default_nettype wire
